ws2812_strip: RTL

Parametrised WS2812 strip driver on the CPU IO bus: holds a NUM_LEDS-entry 24-bit pixel memory written through an index/R/G/B register window and transmits the whole strip as one frame on command, followed by a latch (reset) gap. It extends the single-pixel LED/WS2812 core to arbitrary strip length, exact cycle timing parameters, auto-increment loading, busy/pending status and back-to-back frame requests.

---
 rtl/ws2812_strip.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ws2812_strip.sv
// ws2812_strip: NUM_LEDS-pixel WS2812 driver with INDEX/R/G/B register window and frame sequencer.
// Define WS2812_BRIGHTNESS_EN to add the BRIGHT register (reg 5) and per-channel scaling at LOAD.
module ws2812_strip #(
  parameter int NUM_LEDS = 8,
  parameter int T0H = 11,
  parameter int T0L = 23,
  parameter int T1H = 23,
  parameter int T1L = 11,
  parameter int TRST = 1620
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       R_W_n,
  input  logic [2:0] reg_addr_i,
  input  logic [7:0] data_i,
  input  logic       strip_cs,
  output logic [7:0] data_o,
  output logic       ws2812
);
  localparam int AW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
  localparam int TA = T0H > T0L ? T0H : T0L;
  localparam int TB = T1H > T1L ? T1H : T1L;
  localparam int TC = TA > TB ? TA : TB;
  localparam int TMAX = TC > TRST ? TC : TRST;
  localparam int CW = $clog2(TMAX + 1);
  localparam logic [CW-1:0] C0H = CW'(T0H - 1);
  localparam logic [CW-1:0] C0L = CW'(T0L - 1);
  localparam logic [CW-1:0] C1H = CW'(T1H - 1);
  localparam logic [CW-1:0] C1L = CW'(T1L - 1);
  localparam logic [CW-1:0] CRST = CW'(TRST - 1);
  typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;
  state_t state;
  logic [23:0] pix [1 << AW];
  logic [7:0] index, pix_cnt, rd5;
  logic [4:0] bit_cnt;
  logic [CW-1:0] cnt, th, tl;
  logic [23:0] shreg, cur, nxt, load_word;
  logic autoinc, pending, wr, start, busy, last_pix;
  assign wr = strip_cs & ~R_W_n;
  assign start = wr && reg_addr_i == 3'd4 && data_i[0];
  assign busy = state != IDLE;
  assign cur = pix[index[AW-1:0]];
  assign nxt = pix[pix_cnt[AW-1:0]];
  assign last_pix = {24'd0, pix_cnt} == NUM_LEDS - 1;
  assign th = shreg[23] ? C1H : C0H;
  assign tl = shreg[23] ? C1L : C0L;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] bright;
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * {7'd0, {1'b0, b} + 9'd1};
    return 8'(p >> 8);
  endfunction
  always_ff @(posedge clk_i)
    if (rst_i) bright <= 8'hFF;
    else if (wr && reg_addr_i == 3'd5) bright <= data_i;
  assign rd5 = bright;
  assign load_word = {scale(nxt[15:8], bright), scale(nxt[23:16], bright), scale(nxt[7:0], bright)};
`else
  assign rd5 = 8'd0;
  assign load_word = {nxt[15:8], nxt[23:16], nxt[7:0]};
`endif
  always_comb
    data_o = reg_addr_i == 3'd0 ? index :
             reg_addr_i == 3'd1 ? cur[23:16] :
             reg_addr_i == 3'd2 ? cur[15:8] :
             reg_addr_i == 3'd3 ? cur[7:0] :
             reg_addr_i == 3'd4 ? {5'd0, autoinc, pending, busy} :
             reg_addr_i == 3'd5 ? rd5 : 8'd0;
  always_ff @(posedge clk_i) begin
    if (wr && reg_addr_i == 3'd1) pix[index[AW-1:0]][23:16] <= data_i;
    if (wr && reg_addr_i == 3'd2) pix[index[AW-1:0]][15:8] <= data_i;
    if (wr && reg_addr_i == 3'd3) pix[index[AW-1:0]][7:0] <= data_i;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      index <= 8'd0;
      autoinc <= 1'b0;
    end else if (wr) begin
      if (reg_addr_i == 3'd0 && {24'd0, data_i} < NUM_LEDS) index <= data_i;
      if (reg_addr_i == 3'd3 && autoinc) index <= {24'd0, index} == NUM_LEDS - 1 ? 8'd0 : index + 8'd1;
      if (reg_addr_i == 3'd4) autoinc <= data_i[1];
    end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      ws2812 <= 1'b0;
      pending <= 1'b0;
      pix_cnt <= 8'd0;
      bit_cnt <= 5'd0;
      cnt <= '0;
      shreg <= 24'd0;
    end else begin
      if (start && busy) pending <= 1'b1;
      case (state)
        IDLE: if (start || pending) begin
          state <= LOAD;
          pix_cnt <= 8'd0;
          pending <= 1'b0;
        end
        LOAD: begin
          shreg <= load_word;
          bit_cnt <= 5'd0;
          cnt <= '0;
          ws2812 <= 1'b1;
          state <= HIGH;
        end
        HIGH: if (cnt == th) begin
          cnt <= '0;
          ws2812 <= 1'b0;
          state <= LOW;
        end else cnt <= cnt + 1'b1;
        LOW: if (cnt == tl) begin
          cnt <= '0;
          if (bit_cnt == 5'd23) begin
            if (last_pix) state <= LATCH;
            else begin
              pix_cnt <= pix_cnt + 8'd1;
              state <= LOAD;
            end
          end else begin
            shreg <= {shreg[22:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            ws2812 <= 1'b1;
            state <= HIGH;
          end
        end else cnt <= cnt + 1'b1;
        LATCH: if (cnt == CRST) begin
          cnt <= '0;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule
